// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// default configuration constants, the length-width helper and the
// history-register control encoding.
package seq_det_pkg;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int          DEF_MAX_LEN = 8;
  localparam logic [7:0]  DEF_PATTERN = 8'b0000_1011;
  localparam int          DEF_LEN     = 4;
  localparam logic        DEF_OVERLAP = 1'b1;

  // What the history register does on the coming edge.
  typedef enum logic [1:0] {
    HIST_HOLD  = 2'd0,
    HIST_SHIFT = 2'd1,
    HIST_CLEAR = 2'd2
  } hist_op_e;

endpackage

// File: rtl/seq_det_hist.sv
// History shift register (newest bit at bit 0) with a saturating fill
// counter. It also exposes the shifted "next" view so the top level can
// compare against the values that would be stored on this edge.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int FILL_W  = len_w(DEF_MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  hist_op_e           op,
  input  logic               d,
  output logic [MAX_LEN-1:0] hist,
  output logic [FILL_W-1:0]  fill,
  output logic [MAX_LEN-1:0] next_hist,
  output logic [FILL_W-1:0]  next_fill
);

  // Shifted history and saturating fill, as they would look after accepting d.
  always_comb begin
    next_hist = {hist[MAX_LEN-2:0], d};
    next_fill = (fill == FILL_W'(MAX_LEN)) ? fill : fill + 1'b1;
  end

  // History and fill registers: clear has priority over shift; otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else begin
      case (op)
        HIST_CLEAR: begin
          hist <= '0;
          fill <= '0;
        end
        HIST_SHIFT: begin
          hist <= next_hist;
          fill <= next_fill;
        end
        default: begin
          hist <= hist;
          fill <= fill;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable Moore serial sequence detector. Holds the pattern,
// length and overlap configuration, compares the incoming history against
// the pattern, and drives a registered one-cycle match flag plus a
// saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int              MAX_LEN     = DEF_MAX_LEN,
  parameter int              CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int              RST_LEN     = DEF_LEN,
  parameter logic            RST_OVERLAP = DEF_OVERLAP,
  localparam int             LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               d_valid,
  input  logic               d,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] next_hist;
  logic [LEN_W-1:0]   next_fill;
  logic [MAX_LEN-1:0] mask;
  logic               len_ok;
  logic               match;
  hist_op_e           op;

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .d         (d),
    .hist      (hist),
    .fill      (fill),
    .next_hist (next_hist),
    .next_fill (next_fill)
  );

  // Match decision on the would-be-stored history, and the history control.
  always_comb begin
    // NOTE: defaults first so every path assigns each output, preventing latches.
    mask   = '0;
    len_ok = (len != '0) && (len <= LEN_W'(MAX_LEN));
    match  = 1'b0;
    op     = HIST_HOLD;

    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end

    // A bit is accepted only when valid and not overridden by a config write.
    if (d_valid && !cfg_we && len_ok && (next_fill >= len) &&
        (((next_hist ^ pat) & mask) == '0)) begin
      match = 1'b1;
    end

    if (cfg_we) begin
      op = HIST_CLEAR;
    end else if (match && !ovl) begin
      op = HIST_CLEAR;
    end else if (d_valid) begin
      op = HIST_SHIFT;
    end
  end

  // Configuration registers; an illegal length is stored as given.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= RST_PATTERN;
      len <= LEN_W'(RST_LEN);
      ovl <= RST_OVERLAP;
    end else if (cfg_we) begin
      pat <= cfg_pattern;
      len <= cfg_len;
      ovl <= cfg_overlap;
    end
  end

  // Registered match flag: one cycle high per match.
  always_ff @(posedge clk) begin
    if (rst) begin
      z <= 1'b0;
    end else begin
      z <= match;
    end
  end

  // Saturating match counter; a clear coinciding with a match leaves it at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= match ? CNT_W'(1) : '0;
    end else if (match && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + 1'b1;
    end
  end

endmodule
